// File: rtl/lut_neuron_stream.sv
// rtl/lut_neuron_stream.sv - pipelined multi-lane truth-table neuron with runtime table reload
// Two-stage valid/ready pipe (address reg, table-read reg) around a shared table written through a sequential config port.
module lut_neuron_stream #(
   parameter int IN_W   = 8,
   parameter int OUT_W  = 2,
   parameter int NUM_CH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_CH*IN_W-1:0]    in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_CH*OUT_W-1:0]   out_data,
   input  logic                      cfg_start,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [OUT_W-1:0]          cfg_data,
   output logic                      cfg_done,
   output logic                      table_loaded
);

   typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

   state_t                    state, state_next;
   logic [OUT_W-1:0]          lut [2**IN_W];
   logic                      s1_valid, s2_valid;
   logic [NUM_CH*IN_W-1:0]    s1_addr;
   logic [NUM_CH*OUT_W-1:0]   s2_data;
   logic [IN_W-1:0]           load_addr;
   logic                      s2_adv, accept, cfg_wr, last_wr, pipe_empty;

   assign s2_adv     = !s2_valid || out_ready;
   assign in_ready   = (state == RUN) && !cfg_start && (!s1_valid || s2_adv);
   assign accept     = in_valid && in_ready;
   assign cfg_ready  = (state == LOAD);
   assign cfg_wr     = cfg_valid && cfg_ready;
   assign last_wr    = cfg_wr && (&load_addr);
   assign pipe_empty = !s1_valid && !s2_valid;
   assign out_valid  = s2_valid;
   assign out_data   = s2_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RUN;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (cfg_start)  state_next = DRAIN;
         DRAIN:   if (pipe_empty) state_next = LOAD;
         LOAD:    if (last_wr)    state_next = RUN;
         default:                 state_next = RUN;
      endcase
   end

   // Until a full table has been loaded, results are the all-zero neuron.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_addr  <= '0;
         s2_valid <= 1'b0;
         s2_data  <= '0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
            s1_addr  <= in_data;
         end else if (s2_adv) begin
            s1_valid <= 1'b0;
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               for (int k = 0; k < NUM_CH; k++)
                  s2_data[k*OUT_W +: OUT_W] <= table_loaded ? lut[s1_addr[k*IN_W +: IN_W]] : '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_addr    <= '0;
         cfg_done     <= 1'b0;
         table_loaded <= 1'b0;
      end else begin
         cfg_done <= last_wr;
         if (cfg_wr)  load_addr    <= load_addr + 1'b1;
         if (last_wr) table_loaded <= 1'b1;
      end
   end

   // Table contents survive reset; only the loaded flag gates their use.
   always_ff @(posedge clk) begin
      if (cfg_wr) lut[load_addr] <= cfg_data;
   end

endmodule

// File: tb/tb_lut_neuron_stream.sv
// tb/tb_lut_neuron_stream.sv - directed self-checking bench for lut_neuron_stream
// A negedge monitor checks every output bundle in order against a reference table model.
module tb_lut_neuron_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data;
   logic [7:0]  out_data;
   logic        cfg_start, cfg_valid, cfg_ready, cfg_done, table_loaded;
   logic [1:0]  cfg_data;

   int          n_pass = 0;
   int          n_total = 0;
   logic [1:0]  m_tbl [256];
   bit          m_loaded = 1'b0;
   logic [7:0]  exp_q [$];

   lut_neuron_stream #(.IN_W(8), .OUT_W(2), .NUM_CH(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_data(cfg_data), .cfg_done(cfg_done), .table_loaded(table_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [7:0] model(input logic [31:0] d);
      logic [7:0] r;
      for (int k = 0; k < 4; k++)
         r[k*2 +: 2] = m_loaded ? m_tbl[d[k*8 +: 8]] : 2'b00;
      return r;
   endfunction

   function automatic logic [31:0] pack(input logic [7:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   // Inputs only change just after posedge, so negedge sees the handshake of the coming edge.
   always @(negedge clk) begin
      if (rst) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("extra_output", 32'(out_data), 32'hFFFF_FFFF);
            else check("out_data_order", 32'(out_data), 32'(exp_q.pop_front()));
         end
         if (in_valid && in_ready) exp_q.push_back(model(in_data));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_cfg;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic wait_cfg_ready;
      for (int i = 0; i < 20 && !cfg_ready; i++) tick();
      check("cfg_ready_rise", 32'(cfg_ready), 32'd1);
   endtask

   task automatic write_words(input bit inv, input int n);
      logic [7:0] a;
      logic [1:0] d;
      for (int i = 0; i < n; i++) begin
         a = 8'(i);
         d = inv ? ~a[1:0] : a[1:0];
         cfg_valid = 1'b1;
         cfg_data  = d;
         m_tbl[i]  = d;
         tick();
         if (i == 255) begin
            check("cfg_done_pulse", 32'(cfg_done), 32'd1);
            check("table_loaded_set", 32'(table_loaded), 32'd1);
         end
      end
      cfg_valid = 1'b0;
      if (n == 256) begin
         m_loaded = 1'b1;
         tick();
         check("cfg_done_one_cycle", 32'(cfg_done), 32'd0);
      end
   endtask

   task automatic single(input logic [31:0] d, input string tag, input logic [7:0] exp);
      in_valid = 1'b1;
      in_data  = d;
      #1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check({tag, "_lat1"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, "_lat2"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, 32'(out_data), 32'(exp));
      tick();
   endtask

   initial begin
      int cnt, first, last, idx, acc;
      logic [7:0] held;
      bit stable, took;
      rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
      tick(); tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
      check("rst_cfg_done", 32'(cfg_done), 32'd0);
      check("rst_table_loaded", 32'(table_loaded), 32'd0);
      rst = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // 1: unloaded table gives all-zero results
      single({4{8'h00}}, "t1_00", 8'h00);
      single({4{8'hFF}}, "t1_ff", 8'h00);
      single({4{8'h5A}}, "t1_5a", 8'h00);

      // 2: table[a] = a[1:0]
      start_cfg();
      wait_cfg_ready();
      write_words(1'b0, 256);
      single(pack(8'h07, 8'h00, 8'h00, 8'hFE), "t2", 8'h83);

      // 3: 16 back-to-back bundles
      cnt = 0; first = -1; last = -1;
      for (int i = 0; i < 18; i++) begin
         in_valid = (i < 16);
         in_data  = pack(8'(i*7), 8'(i*7+1), 8'(i*13+2), 8'(255-i));
         tick();
         if (out_valid) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
         end
      end
      in_valid = 1'b0;
      check("t3_valid_count", 32'(cnt), 32'd16);
      check("t3_no_bubble", 32'(last - first + 1), 32'd16);

      // 4: backpressure
      out_ready = 1'b0; idx = 0; acc = 0; stable = 1'b1; held = '0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = pack(8'(idx*3+1), 8'(idx*5), 8'(idx*11+3), 8'(idx+200));
         #1;
         took = in_ready;
         tick();
         if (took) begin idx++; acc++; end
         if (i == 1) held = out_data;
         if (i > 1 && out_data !== held) stable = 1'b0;
      end
      check("t4_accepts", 32'(acc), 32'd2);
      check("t4_in_ready_low", 32'(in_ready), 32'd0);
      check("t4_out_stable", 32'(stable), 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 40 && idx < 5; i++) begin
         in_data = pack(8'(idx*3+1), 8'(idx*5), 8'(idx*11+3), 8'(idx+200));
         #1;
         took = in_ready;
         tick();
         if (took) idx++;
      end
      in_valid = 1'b0;
      check("t4_all_sent", 32'(idx), 32'd5);
      tick(); tick(); tick();
      check("t4_drained", 32'(exp_q.size()), 32'd0);

      // 5: reload with two bundles in flight
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = pack(8'h01, 8'h02, 8'h03, 8'h04); tick();
      in_data = pack(8'h05, 8'h06, 8'h07, 8'h08); tick();
      in_data = pack(8'h09, 8'h0A, 8'h0B, 8'h0C);
      cfg_start = 1'b1;
      #1;
      check("t5_in_ready_cfg_start", 32'(in_ready), 32'd0);
      tick();
      cfg_start = 1'b0; in_valid = 1'b0;
      check("t5_cfg_ready_drain", 32'(cfg_ready), 32'd0);
      check("t5_in_ready_drain", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      wait_cfg_ready();
      check("t5_pipe_drained", 32'(exp_q.size()), 32'd0);
      write_words(1'b1, 256);
      single(pack(8'h07, 8'h00, 8'h00, 8'hFE), "t5_new", 8'h7C);

      // 6: reset in the middle of a load
      start_cfg();
      wait_cfg_ready();
      write_words(1'b0, 100);
      #2 rst = 1'b0;
      #1;
      check("t6_cfg_ready", 32'(cfg_ready), 32'd0);
      check("t6_table_loaded", 32'(table_loaded), 32'd0);
      tick();
      rst = 1'b1;
      exp_q.delete();
      m_loaded = 1'b0;
      single(pack(8'h07, 8'h00, 8'h00, 8'hFE), "t6_zero", 8'h00);
      start_cfg();
      wait_cfg_ready();
      write_words(1'b0, 256);
      single(pack(8'h07, 8'h00, 8'h00, 8'hFE), "t6_reload", 8'h83);

      tick();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
